uart_rx: RTL and testbench

UART receiver, 8N1, LSB first. Pairs with the existing transmitter on the Tang Primer 20K serial link. Samples an asynchronous rx_pin at mid-bit using a baud counter derived from the clock frequency. Delivers each received byte through a valid/ready handshake and flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divisor
// helper also used by the transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } rx_state_e;

   function automatic int unsigned cycles_per_bit(
      input int unsigned clk_fre,
      input int unsigned baud
   );
      return (clk_fre * 32'd1_000_000) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with falling-edge detect; all flops idle high
// so a line held low through reset still yields exactly one edge.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic fall
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         s1_q   <= async_in;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign sync_out = s2_q;
   assign fall     = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, valid/ready output
// with framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FRE   = 27,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   input  logic       rx_data_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int unsigned CYCLE = cycles_per_bit(CLK_FRE, BAUD_RATE);
   localparam int unsigned HALF  = CYCLE / 2;
   localparam logic [15:0] CYC_END  = 16'(CYCLE - 1);
   localparam logic [15:0] HALF_END = 16'(HALF - 1);

   logic rx_s;
   logic rx_fall;

   uart_rx_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (rx_pin),
      .sync_out (rx_s),
      .fall     (rx_fall)
   );

   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      if (valid_q && rx_data_ready) valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rx_fall) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_END) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CYC_END) begin
               cnt_d          = '0;
               shift_d[bit_q] = rx_s;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed
            if (cnt_q == CYC_END) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!rx_s) begin
                  ferr_d = 1'b1;
               end else if (!valid_q || rx_data_ready) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rx_data       = data_q;
   assign rx_data_valid = valid_q;
   assign rx_frame_err  = ferr_q;
   assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 27 MHz / 115200 baud (234 clocks per bit).
module tb_uart_rx;
   import uart_pkg::*;

   localparam int C = 234;
   localparam int H = 117;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_pin = 1'b1;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ready = 1'b1;
   logic       rx_frame_err;
   logic       rx_overrun;

   uart_rx #(.CLK_FRE(27), .BAUD_RATE(115200)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_pin        (rx_pin),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_t = -1;
   int vcyc = 0;
   int ferr_n = 0;
   int ovr_n = 0;
   int both_n = 0;
   logic [7:0] accq[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_data_valid) vcyc++;
      if (rx_data_valid && rx_data_ready) begin
         accq.push_back(rx_data);
         if (first_t < 0) first_t = cyc;
      end
      if (rx_frame_err) ferr_n++;
      if (rx_overrun) ovr_n++;
      if (rx_frame_err && rx_overrun) both_n++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act,
                          input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clear();
      accq.delete();
      first_t = -1;
      vcyc = 0;
      ferr_n = 0;
      ovr_n = 0;
   endtask

   task automatic hold(input logic v, input int n);
      rx_pin = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input int bl);
      hold(1'b0, bl);
      for (int i = 0; i < 8; i++) hold(b[i], bl);
      hold(stop, bl);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         bl;
      int         exp_acc;
      int         exp_ferr;
   } vec_t;

   vec_t vt[5];
   int t0;

   initial begin
      vt[0] = '{8'h55, 1'b1, 234, 1, 0};
      vt[1] = '{8'hC6, 1'b1, 234, 1, 0};
      vt[2] = '{8'hFF, 1'b0, 234, 0, 1};
      vt[3] = '{8'h00, 1'b1, 239, 1, 0};
      vt[4] = '{8'h81, 1'b1, 229, 1, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", int'(rx_data), 0);
      chk("rst_valid", int'(rx_data_valid), 0);
      chk("rst_ferr", int'(rx_frame_err), 0);
      chk("rst_ovr", int'(rx_overrun), 0);
      rst_n = 1'b1;
      hold(1'b1, 20);

      // Single frames, ready held high
      for (int i = 0; i < 5; i++) begin
         clear();
         t0 = cyc;
         send(vt[i].data, vt[i].stop, vt[i].bl);
         hold(1'b1, 2 * C);
         chk($sformatf("v%0d_acc", i), accq.size(), vt[i].exp_acc);
         if (vt[i].exp_acc == 1 && accq.size() == 1)
            chk($sformatf("v%0d_data", i), int'(accq[0]), int'(vt[i].data));
         chk($sformatf("v%0d_vcyc", i), vcyc, vt[i].exp_acc);
         chk($sformatf("v%0d_ferr", i), ferr_n, vt[i].exp_ferr);
         chk($sformatf("v%0d_ovr", i), ovr_n, 0);
         if (i == 0) chk_rng("latency", first_t - t0, 2224, 2228);
      end

      // Overrun: hold ready low across two frames
      clear();
      rx_data_ready = 1'b0;
      send(8'hA3, 1'b1, C);
      hold(1'b1, C);
      chk("ovr_valid1", int'(rx_data_valid), 1);
      chk("ovr_data1", int'(rx_data), 8'hA3);
      send(8'h3C, 1'b1, C);
      hold(1'b1, C);
      chk("ovr_pulses", ovr_n, 1);
      chk("ovr_data2", int'(rx_data), 8'hA3);
      chk("ovr_valid2", int'(rx_data_valid), 1);
      chk("ovr_ferr", ferr_n, 0);
      rx_data_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr_drop", int'(rx_data_valid), 0);
      chk("ovr_acc", accq.size(), 1);
      if (accq.size() == 1) chk("ovr_accd", int'(accq[0]), 8'hA3);

      // Short low glitch is rejected as a false start
      clear();
      hold(1'b0, 10);
      chk("gl_start", int'(dut.state_q), int'(S_START));
      hold(1'b0, 40);
      hold(1'b1, H + 3 - 50);
      chk("gl_idle", int'(dut.state_q), int'(S_IDLE));
      hold(1'b1, 2 * C);
      chk("gl_acc", accq.size(), 0);
      chk("gl_ferr", ferr_n, 0);
      chk("gl_ovr", ovr_n, 0);

      // Back-to-back frames at nominal, +2% and -2% bit length
      for (int k = 0; k < 3; k++) begin
         int bl;
         bl = (k == 0) ? 234 : (k == 1) ? 239 : 229;
         clear();
         send(8'h00, 1'b1, bl);
         send(8'hFF, 1'b1, bl);
         hold(1'b1, 2 * C);
         chk($sformatf("b2b%0d_acc", k), accq.size(), 2);
         if (accq.size() == 2) begin
            chk($sformatf("b2b%0d_d0", k), int'(accq[0]), 8'h00);
            chk($sformatf("b2b%0d_d1", k), int'(accq[1]), 8'hFF);
         end
         chk($sformatf("b2b%0d_ferr", k), ferr_n, 0);
         chk($sformatf("b2b%0d_vcyc", k), vcyc, 2);
      end

      // Reset in the middle of bit 4, then a clean frame
      clear();
      hold(1'b0, C);
      hold(1'b0, C);
      hold(1'b1, C);
      hold(1'b0, C);
      hold(1'b1, C);
      hold(1'b1, C / 2);
      rst_n = 1'b0;
      #2;
      chk("mr_data", int'(rx_data), 0);
      chk("mr_valid", int'(rx_data_valid), 0);
      chk("mr_state", int'(dut.state_q), int'(S_IDLE));
      hold(1'b1, 10);
      rst_n = 1'b1;
      hold(1'b1, 3 * C);
      chk("mr_nopart", accq.size(), 0);
      send(8'h81, 1'b1, C);
      hold(1'b1, 2 * C);
      chk("mr_acc", accq.size(), 1);
      if (accq.size() == 1) chk("mr_data81", int'(accq[0]), 8'h81);
      chk("mr_ferr", ferr_n, 0);

      // Line held low through reset release
      rx_pin = 1'b0;
      rst_n = 1'b0;
      hold(1'b0, 5);
      clear();
      rst_n = 1'b1;
      hold(1'b0, 2 + H + 9 * C + 30);
      chk("brk_ferr", ferr_n, 1);
      chk("brk_acc", accq.size(), 0);
      hold(1'b0, 3 * C);
      chk("brk_ferr2", ferr_n, 1);
      hold(1'b1, 2 * C);
      chk("brk_ferr3", ferr_n, 1);
      chk("brk_acc2", accq.size(), 0);

      chk("err_ovr_same_cycle", both_n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
